// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-scan 3x3 window generator with two column-addressed line buffers
module window_gen_3x3 #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   pix_in,
    input  logic            pix_valid,
    input  logic            sof,
    output logic [9*DW-1:0] win_out,
    output logic            win_en,
    output logic            frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    logic            accept;
    logic [CW-1:0]   c_eff, col_d, col_q;
    logic [RW-1:0]   r_eff, row_d, row_q;
    logic [DW-1:0]   lb0_q [IMG_W];
    logic [DW-1:0]   lb1_q [IMG_W];
    logic [DW-1:0]   win_d [3][3];
    logic [DW-1:0]   win_q [3][3];
    logic [9*DW-1:0] win_out_d, win_out_q;
    logic            win_en_d, win_en_q, frame_done_d, frame_done_q;
    always_comb begin
        accept       = pix_valid && reset;
        c_eff        = sof ? '0 : col_q;
        r_eff        = sof ? '0 : row_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_out_d    = win_out_q;
        win_en_d     = 1'b0;
        frame_done_d = 1'b0;
        if (accept) begin
            col_d = (c_eff == CW'(IMG_W - 1)) ? '0 : c_eff + CW'(1);
            row_d = (c_eff != CW'(IMG_W - 1)) ? r_eff :
                    (r_eff == RW'(IMG_H - 1)) ? '0 : r_eff + RW'(1);
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            // oldest row on top: linebuf1 holds row r-2, linebuf0 row r-1
            win_d[0][2]  = lb1_q[c_eff];
            win_d[1][2]  = lb0_q[c_eff];
            win_d[2][2]  = pix_in;
            win_en_d     = (r_eff >= RW'(2)) && (c_eff >= CW'(2));
            frame_done_d = (r_eff == RW'(IMG_H - 1)) && (c_eff == CW'(IMG_W - 1));
            if (win_en_d)
                for (int k = 0; k < 9; k++)
                    win_out_d[(8 - k)*DW +: DW] = win_d[k/3][k%3];
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_out_q    <= '0;
            win_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_out_q    <= win_out_d;
            win_en_q     <= win_en_d;
            frame_done_q <= frame_done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[c_eff] <= lb0_q[c_eff];
            lb0_q[c_eff] <= pix_in;
        end
    end
    assign win_out    = win_out_q;
    assign win_en     = win_en_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: randomized and directed checks against a full-frame reference image model
module tb_window_gen_3x3;
    localparam int W = 10;
    localparam int H = 10;
    logic        clk = 1'b0, reset = 1'b0, pix_valid = 1'b0, sof = 1'b0;
    logic [7:0]  pix_in = '0;
    logic [71:0] win_out, win_out_s, exp_win = '0, sw;
    logic        win_en, frame_done, win_en_s, frame_done_s;
    logic        exp_en = 1'b0, exp_fd = 1'b0;
    logic [7:0]  img [H][W];
    int          mr = 0, mc = 0, n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_out(win_out), .win_en(win_en), .frame_done(frame_done));
    window_gen_3x3 #(.IMG_W(5), .IMG_H(4), .DW(8)) dut_s (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_out(win_out_s), .win_en(win_en_s), .frame_done(frame_done_s));

    // drive one cycle, then update the frame-image model with what the edge accepted
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        pix_valid = v; sof = s; pix_in = p;
        @(posedge clk); #1;
        if (!reset) begin
            mr = 0; mc = 0; exp_en = 0; exp_fd = 0; exp_win = '0;
        end else if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = p;
            exp_en = (mr >= 2) && (mc >= 2);
            exp_fd = (mr == H - 1) && (mc == W - 1);
            if (exp_en)
                for (int k = 0; k < 9; k++) exp_win[(8 - k)*8 +: 8] = img[mr - 2 + k/3][mc - 2 + k%3];
            mc++;
            if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
        end else begin
            exp_en = 0; exp_fd = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b1, 1'b0, 8'($urandom));
        reset = 1'b1;
    endtask

    function automatic logic [7:0] ramp(input int i);
        return 8'(10*((i % 100)/10) + i % 10);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 8'($urandom));
            n_checks++;
            if (win_en !== 1'b0 || frame_done !== 1'b0 || win_out !== 72'h0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: en=%b fd=%b win=%h, want 0 0 0", i, win_en, frame_done, win_out);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_frame_ramp();
        int wins = 0, fds = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, ramp(i));
            n_checks++;
            if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                n_fail++;
                $display("FAIL ramp px%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", i, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
            end
            wins += int'(win_en); fds += int'(frame_done);
            if (i == 22) begin
                n_checks++;
                if (win_en !== 1'b1 || win_out !== 72'h00_01_02_0A_0B_0C_14_15_16) begin
                    n_fail++;
                    $display("FAIL ramp_first: en=%b win=%h, want 1 0001020a0b0c141516", win_en, win_out);
                end
            end
            if (i == 99) begin
                n_checks++;
                if (win_en !== 1'b1 || frame_done !== 1'b1 || win_out !== 72'h4D_4E_4F_57_58_59_61_62_63) begin
                    n_fail++;
                    $display("FAIL ramp_last: en=%b fd=%b win=%h, want 1 1 4d4e4f575859616263", win_en, frame_done, win_out);
                end
            end
        end
        n_checks++;
        if (wins != 64 || fds != 1) begin
            n_fail++;
            $display("FAIL ramp_count: wins=%0d fds=%0d, want 64 1", wins, fds);
        end
    endtask

    task automatic test_gaps();
        int wins = 0, px = 0;
        for (int t = 0; t < 150; t++) begin
            if (t % 3 == 2) step(1'b0, 1'b0, 8'($urandom));
            else begin step(1'b1, 1'b0, ramp(px)); px++; end
            n_checks++;
            if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                n_fail++;
                $display("FAIL gaps cyc%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", t, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
            end
            wins += int'(win_en);
        end
        n_checks++;
        if (wins != 64) begin
            n_fail++;
            $display("FAIL gaps_count: wins=%0d, want 64", wins);
        end
    endtask

    task automatic test_back_to_back();
        int wins = 0, fds = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, ramp(i) + (i >= 100 ? 8'h80 : 8'h00));
            n_checks++;
            if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                n_fail++;
                $display("FAIL b2b px%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", i, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
            end
            wins += int'(win_en); fds += int'(frame_done);
            if (i == 122) begin
                n_checks++;
                if (win_en !== 1'b1 || win_out !== 72'h80_81_82_8A_8B_8C_94_95_96) begin
                    n_fail++;
                    $display("FAIL b2b_first2: en=%b win=%h, want 1 8081828a8b8c949596", win_en, win_out);
                end
            end
        end
        n_checks++;
        if (wins != 128 || fds != 2) begin
            n_fail++;
            $display("FAIL b2b_count: wins=%0d fds=%0d, want 128 2", wins, fds);
        end
    endtask

    task automatic test_sof_mid();
        int first_k = -1;
        do_reset();
        for (int i = 0; i < 75; i++) begin
            step(1'b1, i == 45, i < 45 ? ramp(i) : 8'($urandom));
            n_checks++;
            if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                n_fail++;
                $display("FAIL sof px%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", i, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
            end
            if (i >= 45 && first_k < 0 && win_en === 1'b1) first_k = i - 45;
        end
        n_checks++;
        if (first_k != 22) begin
            n_fail++;
            $display("FAIL sof_latency: first window %0d pixels after sof, want 22", first_k);
        end
    endtask

    task automatic test_reset_mid();
        int wins = 0, fds = 0;
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, ramp(i));
        reset = 1'b0;
        step(1'b1, 1'b0, 8'hAA);
        reset = 1'b1;
        n_checks++;
        if (win_en !== 1'b0 || frame_done !== 1'b0 || win_out !== 72'h0) begin
            n_fail++;
            $display("FAIL rmid_during: en=%b fd=%b win=%h, want 0 0 0", win_en, frame_done, win_out);
        end
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, ramp(i) + 8'h40);
            n_checks++;
            if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                n_fail++;
                $display("FAIL rmid px%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", i, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
            end
            wins += int'(win_en); fds += int'(frame_done);
        end
        n_checks++;
        if (wins != 64 || fds != 1) begin
            n_fail++;
            $display("FAIL rmid_count: wins=%0d fds=%0d, want 64 1", wins, fds);
        end
    endtask

    task automatic test_random();
        int wins = 0, fds = 0, cyc = 0;
        for (int f = 0; f < 3; f++) begin
            int px = 0;
            while (px < 100) begin
                if ($urandom_range(3) == 0) step(1'b0, 1'($urandom), 8'($urandom));
                else begin step(1'b1, px == 0, 8'($urandom)); px++; end
                n_checks++;
                if (win_en !== exp_en || frame_done !== exp_fd || win_out !== exp_win) begin
                    n_fail++;
                    $display("FAIL rand cyc%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", cyc, win_en, frame_done, win_out, exp_en, exp_fd, exp_win);
                end
                wins += int'(win_en); fds += int'(frame_done); cyc++;
            end
        end
        n_checks++;
        if (wins != 192 || fds != 3) begin
            n_fail++;
            $display("FAIL rand_count: wins=%0d fds=%0d, want 192 3", wins, fds);
        end
    endtask

    task automatic test_small();
        int wins = 0, fd_at = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            int r = i / 5, c = i % 5;
            logic e = (r >= 2) && (c >= 2);
            step(1'b1, 1'b0, 8'(10*r + c));
            for (int k = 0; k < 9; k++) sw[(8 - k)*8 +: 8] = 8'(10*(r - 2 + k/3) + (c - 2 + k%3));
            n_checks++;
            if (win_en_s !== e || frame_done_s !== (r == 3 && c == 4) || (e && win_out_s !== sw)) begin
                n_fail++;
                $display("FAIL small px%0d: en=%b fd=%b win=%h, want en=%b fd=%b win=%h", i, win_en_s, frame_done_s, win_out_s, e, (r == 3 && c == 4), sw);
            end
            wins += int'(win_en_s);
            if (frame_done_s === 1'b1) fd_at = wins;
        end
        n_checks++;
        if (wins != 6 || fd_at != 6) begin
            n_fail++;
            $display("FAIL small_count: wins=%0d fd_on_window=%0d, want 6 6", wins, fd_at);
        end
    endtask

    initial begin
        test_reset();
        test_frame_ramp();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        test_random();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
